// File: rtl/md5_pad_pkg.sv
// md5_pad_pkg: shared constants, FSM state type and byte-placement helpers
// for the MD5 single-block padder.
package md5_pad_pkg;

  localparam int         MD5_MAX_SB_LEN = 55;     // longest string that still fits one block
  localparam logic [7:0] MD5_PAD_BYTE   = 8'h80;  // terminator byte after the data
  localparam int         MD5_LEN_OFS    = 56;     // byte index of the 64-bit LE length field

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PAD  = 2'd1,
    ST_OUT  = 2'd2
  } pad_state_t;

  // Bit position of the LSB of block byte idx; byte 0 occupies [511:504].
  function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
    return 9'd504 - {idx, 3'b000};
  endfunction

  // Message length in bits for an n-byte string (8n <= 440 fits 16 bits).
  function automatic logic [15:0] bit_len(input logic [5:0] n);
    return {7'd0, n, 3'b000};
  endfunction

endpackage

// File: rtl/md5_pad_outreg.sv
// md5_pad_outreg: 512-bit valid/ready holding register used as a skid stage
// between the padder's assembly buffer and the md5 core.
module md5_pad_outreg
  import md5_pad_pkg::*;
#(
  parameter int W = 512
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_can_load
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // A new block may enter when empty or when the current one leaves this cycle.
  assign o_can_load = ~r_valid | i_ready;
  assign o_data     = r_data;
  assign o_valid    = r_valid;

  // Hold the block until the downstream handshake; reload takes priority.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/md5_pad.sv
// md5_pad: collects a 1..MAX_LEN byte string and emits the single padded
// 512-bit MD5 block (data, 0x80, zeros, 64-bit LE bit length) on valid/ready.
// Byte k of the block sits at o_mesg_out[511-8k -: 8].
// Build option MD5_PAD_SKID_EN: adds md5_pad_outreg so the next string can be
// loaded while the finished block waits for the core.
//
// state | meaning
// LOAD  | accepting string bytes into the assembly buffer
// PAD   | writing 0x80 and the length field (skid build: stalls here while output is full)
// OUT   | block presented, waiting for the downstream handshake (single-buffer build only)
module md5_pad
  import md5_pad_pkg::*;
#(
  parameter int MAX_LEN = MD5_MAX_SB_LEN
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_in_data,
  input  logic         i_in_valid,
  input  logic         i_in_last,
  output logic         o_in_ready,
  output logic [511:0] o_mesg_out,
  output logic         o_mesg_valid,
  input  logic         i_mesg_ready,
  output logic         o_len_err
);

  localparam logic [5:0] LP_MAX    = 6'(MAX_LEN);
  localparam logic [5:0] LP_LEN_LO = 6'(MD5_LEN_OFS);
  localparam logic [5:0] LP_LEN_HI = 6'(MD5_LEN_OFS + 1);

  pad_state_t   r_state;
  logic [5:0]   r_count;
  logic         r_ovf;
  logic [511:0] r_buf;
  logic         r_in_ready;
  logic         r_mesg_valid;
  logic         r_len_err;

  logic         w_accept;
  logic         w_full;
  logic         w_ovf_now;
  logic [8:0]   w_lsb;
  logic [15:0]  w_len;
  logic [511:0] w_padded;

  assign w_accept  = i_in_valid & r_in_ready;
  assign w_full    = (r_count >= LP_MAX);
  assign w_ovf_now = r_ovf | w_full;
  assign w_lsb     = byte_lsb(r_count);
  assign w_len     = bit_len(r_count);

  // Finished block: buffer contents with terminator and length overlaid.
  // Bytes past the data are already zero because the buffer is cleared at every handoff.
  always_comb begin
    w_padded                              = r_buf;
    w_padded[w_lsb +: 8]                  = MD5_PAD_BYTE;
    w_padded[byte_lsb(LP_LEN_LO) +: 8]    = w_len[7:0];
    w_padded[byte_lsb(LP_LEN_HI) +: 8]    = w_len[15:8];
    w_padded[47:0]                        = '0;
  end

`ifdef MD5_PAD_SKID_EN
  logic w_can_handoff;
  logic w_out_load;

  assign w_out_load = (r_state == ST_PAD) & w_can_handoff;

  md5_pad_outreg #(.W(512)) u_outreg (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_out_load),
    .i_data     (w_padded),
    .o_data     (o_mesg_out),
    .o_valid    (o_mesg_valid),
    .i_ready    (i_mesg_ready),
    .o_can_load (w_can_handoff)
  );
`else
  assign o_mesg_out   = r_buf;
  assign o_mesg_valid = r_mesg_valid;
`endif

  assign o_in_ready = r_in_ready;
  assign o_len_err  = r_len_err;

  // Padder FSM with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_LOAD;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_buf        <= '0;
      r_in_ready   <= 1'b1;
      r_mesg_valid <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            // Count saturates at MAX_LEN; extra bytes only mark the string as too long.
            if (!w_full) begin
              r_buf[w_lsb +: 8] <= i_in_data;
              r_count           <= r_count + 6'd1;
            end else begin
              r_ovf <= 1'b1;
            end
            if (i_in_last) begin
              if (w_ovf_now) begin
                r_len_err <= 1'b1;
                r_buf     <= '0;
                r_count   <= '0;
                r_ovf     <= 1'b0;
              end else begin
                r_state    <= ST_PAD;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        ST_PAD: begin
`ifdef MD5_PAD_SKID_EN
          if (w_can_handoff) begin
            r_buf      <= '0;
            r_count    <= '0;
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
          end
`else
          r_buf        <= w_padded;
          r_state      <= ST_OUT;
          r_mesg_valid <= 1'b1;
`endif
        end
        ST_OUT: begin
          if (i_mesg_ready) begin
            r_buf        <= '0;
            r_count      <= '0;
            r_mesg_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end
        default: begin
          r_state    <= ST_LOAD;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
